// File: rtl/jpl_foc_inv_clarke.sv
// rtl/jpl_foc_inv_clarke.sv - inverse Clarke transform (alpha/beta to three-phase), saturated
// Four-state sequencer: latch inputs, multiply beta by sqrt(3)/2, sum and saturate, pulse done.
module jpl_foc_inv_clarke #(
  parameter int B = 12,
  parameter int F = 15
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start_inv_clarke,
  input  logic signed [B-1:0] i_valpha,
  input  logic signed [B-1:0] i_vbeta,
  output logic                o_busy,
  output logic                o_inv_clarke_done,
  output logic signed [B-1:0] o_va,
  output logic signed [B-1:0] o_vb,
  output logic signed [B-1:0] o_vc
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MULT = 2'd1;
  localparam logic [1:0] SUM  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam int PW    = B + F + 1;
  localparam int SW    = PW + 1;
  localparam int K_INT = $rtoi(0.8660254037844386 * (2.0 ** F) + 0.5);

  localparam logic signed [PW-1:0] K    = PW'(K_INT);
  localparam logic signed [PW-1:0] HALF = PW'(2 ** (F - 1));
  localparam logic signed [SW-1:0] SMAX = SW'((2 ** (B - 1)) - 1);
  localparam logic signed [SW-1:0] SMIN = -SW'(2 ** (B - 1));

  logic [1:0]           state;
  logic signed [B-1:0]  alpha_q;
  logic signed [B-1:0]  beta_q;
  logic signed [PW-1:0] t_q;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] prod_rnd;
  logic signed [PW-1:0] t_next;
  logic signed [SW-1:0] half_a;
  logic signed [SW-1:0] t_ext;
  logic signed [SW-1:0] sum_b;
  logic signed [SW-1:0] sum_c;

  // Adding half an LSB before the arithmetic shift makes t round half up.
  assign prod     = K * PW'(beta_q);
  assign prod_rnd = prod + HALF;
  assign t_next   = prod_rnd >>> F;

  assign half_a = SW'(alpha_q >>> 1);
  assign t_ext  = SW'(t_q);
  assign sum_b  = -half_a + t_ext;
  assign sum_c  = -half_a - t_ext;

  assign o_busy = (state != IDLE);

  function automatic logic signed [B-1:0] sat(input logic signed [SW-1:0] x);
    if (x > SMAX) return SMAX[B-1:0];
    if (x < SMIN) return SMIN[B-1:0];
    return x[B-1:0];
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state             <= IDLE;
      alpha_q           <= '0;
      beta_q            <= '0;
      t_q               <= '0;
      o_va              <= '0;
      o_vb              <= '0;
      o_vc              <= '0;
      o_inv_clarke_done <= 1'b0;
    end else begin
      o_inv_clarke_done <= (state == DONE);
      case (state)
        IDLE: begin
          if (i_start_inv_clarke) begin
            alpha_q <= i_valpha;
            beta_q  <= i_vbeta;
            state   <= MULT;
          end
        end
        MULT: begin
          t_q   <= t_next;
          state <= SUM;
        end
        SUM: begin
          o_va  <= alpha_q;
          o_vb  <= sat(sum_b);
          o_vc  <= sat(sum_c);
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jpl_foc_inv_clarke.sv
// tb/tb_jpl_foc_inv_clarke.sv - scoreboard bench for jpl_foc_inv_clarke
// Expected results are queued at start and popped whenever the done pulse is seen.
module tb_jpl_foc_inv_clarke;

  typedef struct {
    int va;
    int vb;
    int vc;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [11:0] valpha;
  logic signed [11:0] vbeta;
  logic               busy;
  logic               done;
  logic signed [11:0] va;
  logic signed [11:0] vb;
  logic signed [11:0] vc;

  int   n_cmp;
  int   n_bad;
  int   done_seen;
  exp_t sb[$];
  exp_t last;

  jpl_foc_inv_clarke #(.B(12), .F(15)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_start_inv_clarke (start),
    .i_valpha           (valpha),
    .i_vbeta            (vbeta),
    .o_busy             (busy),
    .o_inv_clarke_done  (done),
    .o_va               (va),
    .o_vb               (vb),
    .o_vc               (vc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat12(input int x);
    if (x > 2047) return 2047;
    if (x < -2048) return -2048;
    return x;
  endfunction

  function automatic exp_t model(input int a, input int b);
    exp_t m;
    int   t;
    t    = (28378 * b + 16384) >>> 15;
    m.va = a;
    m.vb = sat12(-(a >>> 1) + t);
    m.vc = sat12(-(a >>> 1) - t);
    return m;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("va", int'(va), e.va);
        check("vb", int'(vb), e.vb);
        check("vc", int'(vc), e.vc);
      end
    end
  end

  task automatic run_xform(input int a, input int b, input exp_t e);
    int n;
    @(negedge clk);
    valpha = 12'(a);
    vbeta  = 12'(b);
    start  = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    valpha = 12'(~a);
    vbeta  = 12'(~b);
    n = 1;
    check("busy_mult", int'(busy), 1);
    while (!done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 4);
    check("busy_after", int'(busy), 0);
    #1;
    check("sb_drain", sb.size(), 0);
    last = e;
    @(negedge clk);
    check("done_width", int'(done), 0);
  endtask

  initial begin
    int d0;
    n_cmp     = 0;
    n_bad     = 0;
    done_seen = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    valpha    = '0;
    vbeta     = '0;
    repeat (2) @(negedge clk);
    check("rst_va", int'(va), 0);
    check("rst_vb", int'(vb), 0);
    check("rst_vc", int'(vc), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    rst_n = 1'b1;

    run_xform(1000, 0, '{1000, -500, -500});
    run_xform(0, 1000, '{0, 866, -866});
    run_xform(0, -1000, '{0, -866, 866});
    run_xform(-2048, 2047, '{-2048, 2047, -749});
    run_xform(-3, 0, '{-3, 2, 2});

    // Outputs must hold while idle even as inputs move.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      valpha = 12'($urandom);
      vbeta  = 12'($urandom);
    end
    @(negedge clk);
    check("hold_va", int'(va), last.va);
    check("hold_vb", int'(vb), last.vb);
    check("hold_vc", int'(vc), last.vc);

    // Second start while busy is ignored, along with its inputs.
    d0 = done_seen;
    @(negedge clk);
    valpha = 12'(600);
    vbeta  = 12'(-200);
    start  = 1'b1;
    sb.push_back(model(600, -200));
    @(negedge clk);
    valpha = 12'(-1500);
    vbeta  = 12'(1500);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("busy_drain", sb.size(), 0);
    check("busy_dones", done_seen - d0, 1);

    // Start held high: a new transform every four cycles.
    d0 = done_seen;
    @(negedge clk);
    start  = 1'b1;
    valpha = 12'(400);
    vbeta  = 12'(-700);
    sb.push_back(model(400, -700));
    @(negedge clk);
    valpha = 12'(-1);
    vbeta  = 12'(5);
    repeat (3) @(negedge clk);
    valpha = 12'(-1234);
    vbeta  = 12'(321);
    sb.push_back(model(-1234, 321));
    @(negedge clk);
    valpha = 12'(77);
    vbeta  = 12'(-77);
    repeat (3) @(negedge clk);
    valpha = 12'(2047);
    vbeta  = 12'(-2048);
    sb.push_back(model(2047, -2048));
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("burst_drain", sb.size(), 0);
    check("burst_dones", done_seen - d0, 3);

    // Reset in the middle of a transform aborts it without a done pulse.
    run_xform(-3, 0, '{-3, 2, 2});
    d0 = done_seen;
    @(negedge clk);
    valpha = 12'(700);
    vbeta  = 12'(300);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_va", int'(va), 0);
    check("abort_vb", int'(vb), 0);
    check("abort_vc", int'(vc), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", done_seen - d0, 0);
    check("abort_idle_va", int'(va), 0);
    run_xform(-1000, 500, model(-1000, 500));

    for (int i = 0; i < 64; i++) begin
      for (int j = 0; j < 64; j++) begin
        run_xform(-2048 + 64 * i, -2048 + 64 * j, model(-2048 + 64 * i, -2048 + 64 * j));
      end
    end
    run_xform(2047, 2047, model(2047, 2047));
    run_xform(-2048, -2048, model(-2048, -2048));
    run_xform(2047, -2048, model(2047, -2048));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jpl_foc_inv_clarke.md
JPL_FOC_INV_CLARKE -- requirements
Module: jpl_foc_inv_clarke

Interface
REQ-001 The block SHALL have parameter B, default 12, giving the signed two's-complement width of all data ports.
REQ-002 The block SHALL have parameter F, default 15, giving the number of fractional bits of the internal constant K = round(sqrt(3)/2 * 2^F), which is 28378 for F=15.
REQ-003 The block SHALL have the following ports, clock and reset first:
- i_clk  in  1  sole clock; all state updates on its rising edge.
- i_rst_n  in  1  reset; asynchronous and active-low.
- i_start_inv_clarke  in  1  single-cycle request to start a transform.
- i_valpha  in  B signed  alpha-axis input.
- i_vbeta  in  B signed  beta-axis input.
- o_busy  out  1  high while not in IDLE.
- o_inv_clarke_done  out  1  one-cycle completion pulse.
- o_va  out  B signed  phase A result.
- o_vb  out  B signed  phase B result.
- o_vc  out  B signed  phase C result.

Function
REQ-004 The block SHALL compute the following, saturated to [-2^(B-1), 2^(B-1)-1]:
- va = valpha
- vb = -(valpha>>>1) + t
- vc = -(valpha>>>1) - t
- where t = (K*vbeta + 2^(F-1)) >>> F.
REQ-005 The >>> operator SHALL be an arithmetic shift, so results are floored; t is therefore round-half-up.
REQ-006 The product K*vbeta SHALL be held in at least B+F+1 bits, and the sums in at least B+2 bits before saturation.
REQ-007 The FSM SHALL have four states: IDLE, MULT, SUM, DONE.
REQ-008 In IDLE, when i_start_inv_clarke is sampled high, the block SHALL latch i_valpha and i_vbeta and move to MULT.
REQ-009 In MULT, the block SHALL register t and move to SUM.
REQ-010 In SUM, the block SHALL register the saturated o_va, o_vb and o_vc and move to DONE.
REQ-011 In DONE, o_inv_clarke_done SHALL be high for exactly one cycle, after which the FSM returns to IDLE.
REQ-012 Latency: if start is sampled at edge k, the new outputs and o_inv_clarke_done SHALL be valid after edge k+3.
REQ-013 The earliest next accepted start SHALL be at edge k+4.
REQ-014 i_start_inv_clarke SHALL be ignored in MULT, SUM and DONE; no queuing and no effect on the operation in progress.
REQ-015 Input changes after the latch edge SHALL NOT affect the result in progress.
REQ-016 o_va, o_vb and o_vc SHALL hold their last values until the next SUM state; they do not change at any other time.
REQ-017 o_busy SHALL be high in MULT, SUM and DONE, and low in IDLE.
REQ-018 A start held high continuously SHALL start a new transform every 4 cycles.

Reset
REQ-019 While i_rst_n is low, the block SHALL immediately (asynchronously) set:
- FSM to IDLE
- o_va, o_vb, o_vc to 0
- o_inv_clarke_done to 0
- o_busy to 0
- latched inputs and t to 0
REQ-020 Reset asserted mid-operation SHALL abort the transform; no done pulse is produced for it.
REQ-021 After reset release, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification (B=12, F=15)
REQ-022 Nominal cosine: valpha=1000, vbeta=0, start pulse -> done after edge k+3; va=1000, vb=-500, vc=-500.
REQ-023 Beta rounding:
- vbeta=1000, valpha=0 -> va=0, vb=866, vc=-866.
- vbeta=-1000, valpha=0 -> vb=-866, vc=866.
REQ-024 Saturation: valpha=-2048, vbeta=2047 -> va=-2048, vb=2047 (saturated from 2797), vc=-749.
REQ-025 Odd negative alpha: valpha=-3, vbeta=0 -> va=-3, vb=2, vc=2 (floored shift).
REQ-026 Start while busy: start pulses at k and k+1, inputs changed at k+1 -> exactly one done pulse, with results from the k inputs.
REQ-027 Reset at k+2 of an active transform -> all outputs are 0 and no done pulse; a start two cycles after release gives correct results.
REQ-028 The bench SHALL compare every done result against a bit-exact reference model across a full sweep of valpha and vbeta in steps of 64.
